freq_counter_multi: RTL and testbench

Parametrised multi-channel gated frequency counter core. It is the successor to the single-channel measurement path behind the UART/LED front end. It counts edges on CHANNELS asynchronous measure inputs over a programmable gate of clk_i cycles. Per-channel results (count plus overflow flag) are delivered sequentially over a valid/ready stream to the UART formatter. A continuous mode re-arms the gate with zero dead time.

---
 rtl/freq_counter_multi.sv | 179 +++++++++++++++++
 tb/tb_freq_counter_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_multi.sv
// Multi-channel gated edge counter: per-channel synchronisers feed saturating counters
// over a shared gate; each gate's snapshot is unloaded as a channel-ordered valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for start_i
// GATE   | gate timer running, counters live; previous snapshot may still be unloading
// UNLOAD | no gate running, draining the final snapshot
module freq_counter_multi #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int GATE_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic [CHANNELS-1:0]                                 measure_signal_i,
  input  logic [GATE_WIDTH-1:0]                               gate_cycles_i,
  input  logic [1:0]                                          edge_mode_i,
  input  logic                                                continuous_i,
  input  logic                                                start_i,
  input  logic                                                stop_i,
  output logic                                                busy_o,
  output logic                                                gate_done_o,
  output logic                                                result_valid_o,
  input  logic                                                result_ready_i,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  result_channel_o,
  output logic [COUNT_WIDTH-1:0]                              result_count_o,
  output logic                                                result_overflow_o,
  output logic                                                overrun_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GATE, ST_UNLOAD} state_t;

  state_t                  state_q;
  logic [GATE_WIDTH-1:0]   timer_q;
  logic [GATE_WIDTH-1:0]   g_m1_q;
  logic [1:0]              mode_q;
  logic                    stop_pend_q;

  logic [SYNC_STAGES-1:0]  sync_q [CHANNELS];
  logic [CHANNELS-1:0]     hist_q;
  logic [CHANNELS-1:0]     cur_lvl;
  logic [CHANNELS-1:0]     rise_vec;
  logic [CHANNELS-1:0]     fall_vec;
  logic [CHANNELS-1:0]     edge_pulse;

  logic [COUNT_WIDTH-1:0]  cnt_q  [CHANNELS];
  logic [COUNT_WIDTH-1:0]  cnt_nx [CHANNELS];
  logic [COUNT_WIDTH-1:0]  snap_q [CHANNELS];
  logic [CHANNELS-1:0]     ovf_q;
  logic [CHANNELS-1:0]     ovf_nx;
  logic [CHANNELS-1:0]     snap_ovf_q;

  logic                    handshake;
  logic                    last_beat;
  logic                    beats_remain;
  logic                    rearm;
  logic [GATE_WIDTH-1:0]   g_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], measure_signal_i[i]};
        hist_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    cur_lvl = '0;
    for (int i = 0; i < CHANNELS; i++) cur_lvl[i] = sync_q[i][SYNC_STAGES-1];
  end

  assign rise_vec   = cur_lvl & ~hist_q;
  assign fall_vec   = ~cur_lvl & hist_q;
  assign edge_pulse = mode_q[1] ? (rise_vec | fall_vec) : (mode_q[0] ? fall_vec : rise_vec);

  // Saturate at all ones; the blocked increment is recorded as overflow instead.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nx[i] = cnt_q[i];
      ovf_nx[i] = ovf_q[i];
      if (edge_pulse[i]) begin
        if (&cnt_q[i]) ovf_nx[i] = 1'b1;
        else           cnt_nx[i] = cnt_q[i] + COUNT_WIDTH'(1);
      end
    end
  end

  assign handshake    = result_valid_o && result_ready_i;
  assign last_beat    = handshake && (result_channel_o == CH_W'(CHANNELS - 1));
  assign beats_remain = result_valid_o && !last_beat;
  assign rearm        = continuous_i && !(stop_pend_q || stop_i);
  assign g_load       = (gate_cycles_i == '0) ? '0 : gate_cycles_i - GATE_WIDTH'(1);

  assign busy_o            = (state_q != ST_IDLE);
  assign result_count_o    = snap_q[result_channel_o];
  assign result_overflow_o = snap_ovf_q[result_channel_o];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      timer_q          <= '0;
      g_m1_q           <= '0;
      mode_q           <= '0;
      stop_pend_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q            <= '0;
      snap_ovf_q       <= '0;
      result_valid_o   <= 1'b0;
      result_channel_o <= '0;
      gate_done_o      <= 1'b0;
      overrun_o        <= 1'b0;
    end else begin
      gate_done_o <= 1'b0;

      if (handshake) begin
        if (last_beat) begin
          result_valid_o   <= 1'b0;
          result_channel_o <= '0;
        end else begin
          result_channel_o <= result_channel_o + CH_W'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_GATE;
            timer_q   <= g_load;
            g_m1_q    <= g_load;
            mode_q    <= edge_mode_i;
            overrun_o <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            ovf_q     <= '0;
          end
        end
        ST_GATE: begin
          if (timer_q == '0) begin
            gate_done_o <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
            // A last-beat handshake on this edge frees the stream for the new snapshot.
            if (beats_remain) begin
              overrun_o <= 1'b1;
            end else begin
              for (int i = 0; i < CHANNELS; i++) snap_q[i] <= cnt_nx[i];
              snap_ovf_q       <= ovf_nx;
              result_valid_o   <= 1'b1;
              result_channel_o <= '0;
            end
            if (rearm) timer_q <= g_m1_q;
            else       state_q <= ST_UNLOAD;
          end else begin
            timer_q <= timer_q - GATE_WIDTH'(1);
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_nx[i];
            ovf_q <= ovf_nx;
          end
        end
        ST_UNLOAD: begin
          if (last_beat) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (state_q == ST_UNLOAD && last_beat) stop_pend_q <= 1'b0;
      else if (state_q != ST_IDLE && stop_i) stop_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_counter_multi.sv
// Bench for freq_counter_multi: event-level reference model checked every cycle,
// directed test-plan scenarios with literal expectations, then randomized traffic.
module tb_freq_counter_multi;

  localparam int CH = 4;
  localparam int CW = 32;
  localparam int SS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  meas = '0;
  logic [31:0] gate = '0;
  logic [1:0]  edge_mode = '0;
  logic        cont = 1'b0, start = 1'b0, stop = 1'b0, ready = 1'b0;
  logic        busy, done, valid, rovf, overrun;
  logic [1:0]  rch;
  logic [31:0] rcnt;

  logic [3:0]  w4_meas = '0;
  logic        w4_start = 1'b0;
  logic        w4_busy, w4_done, w4_valid, w4_rovf, w4_overrun;
  logic [1:0]  w4_rch;
  logic [3:0]  w4_rcnt;

  freq_counter_multi #(.CHANNELS(CH), .COUNT_WIDTH(CW), .GATE_WIDTH(32), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .measure_signal_i(meas), .gate_cycles_i(gate),
    .edge_mode_i(edge_mode), .continuous_i(cont), .start_i(start), .stop_i(stop),
    .busy_o(busy), .gate_done_o(done), .result_valid_o(valid), .result_ready_i(ready),
    .result_channel_o(rch), .result_count_o(rcnt), .result_overflow_o(rovf),
    .overrun_o(overrun));

  freq_counter_multi #(.CHANNELS(CH), .COUNT_WIDTH(4), .GATE_WIDTH(32), .SYNC_STAGES(SS)) dut_w4 (
    .clk_i(clk), .rst_i(rst), .measure_signal_i(w4_meas), .gate_cycles_i(gate),
    .edge_mode_i(edge_mode), .continuous_i(cont), .start_i(w4_start), .stop_i(stop),
    .busy_o(w4_busy), .gate_done_o(w4_done), .result_valid_o(w4_valid), .result_ready_i(ready),
    .result_channel_o(w4_rch), .result_count_o(w4_rcnt), .result_overflow_o(w4_rovf),
    .overrun_o(w4_overrun));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; longint cnt; bit ovf; } beat_t;

  int         cyc = 0;
  logic [3:0] hist [0:65535];
  bit         m_gate = 0, m_stop = 0, m_done = 0, m_ovr = 0;
  int         g_start = 0, g_end = 0, g_len = 1;
  logic [1:0] m_mode = '0;
  beat_t      q[$];

  // Edge seen at clock edge k is the transition between input samples taken SS and SS+1 edges earlier.
  function automatic longint count_edges(int ch, int from, int to, logic [1:0] md);
    longint n = 0;
    for (int k = from; k <= to; k++) begin
      logic a, b;
      a = (k - SS - 1 >= 0) ? hist[k - SS - 1][ch] : 1'b0;
      b = (k - SS >= 0) ? hist[k - SS][ch] : 1'b0;
      if (md[1])         n += ((a != b) ? 1 : 0);
      else if (md == 2'b01) n += ((a && !b) ? 1 : 0);
      else               n += ((!a && b) ? 1 : 0);
    end
    return n;
  endfunction

  always @(posedge clk) begin : model
    bit was_busy;
    longint n, maxv;
    beat_t b;
    hist[cyc] = rst ? 4'b0 : meas;
    if (rst) begin
      m_gate = 0; m_stop = 0; m_done = 0; m_ovr = 0;
      q.delete();
    end else begin
      was_busy = m_gate || (q.size() > 0);
      m_done = 0;
      if (q.size() > 0 && ready) void'(q.pop_front());
      if (m_gate && cyc == g_end) begin
        m_done = 1;
        if (q.size() > 0) m_ovr = 1;
        else begin
          maxv = (longint'(1) << CW) - 1;
          for (int c = 0; c < CH; c++) begin
            n = count_edges(c, g_start + 1, g_end, m_mode);
            b.ch = c; b.cnt = (n > maxv) ? maxv : n; b.ovf = (n > maxv);
            q.push_back(b);
          end
        end
        if (cont && !(m_stop || stop)) begin
          g_start = cyc; g_end = cyc + g_len;
        end else m_gate = 0;
      end else if (!was_busy && start) begin
        m_gate = 1; g_len = (gate == 0) ? 1 : int'(gate);
        g_start = cyc; g_end = cyc + g_len; m_mode = edge_mode; m_ovr = 0;
      end
      if (!(m_gate || q.size() > 0)) m_stop = 0;
      else if (stop && was_busy) m_stop = 1;
    end
    cyc++;
  end

  bit cmp_en = 0;
  always @(negedge clk) if (cmp_en) begin
    chk("busy", busy, (m_gate || q.size() > 0));
    chk("gate_done", done, m_done);
    chk("valid", valid, (q.size() > 0));
    chk("overrun", overrun, m_ovr);
    if (q.size() > 0) begin
      chk("beat_channel", rch, q[0].ch);
      chk("beat_count", rcnt, q[0].cnt);
      chk("beat_overflow", rovf, q[0].ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit wave_en = 0, rand_en = 0;
  int wc = 0;
  always @(posedge clk) begin
    #1;
    if (wave_en) begin
      meas[0] = ((wc / 25) % 2) == 1;
      meas[1] = ((wc / 50) % 2) == 1;
      meas[2] = 1'b0;
      meas[3] = ((wc / 5) % 2) == 1;
    end else if (rand_en) begin
      meas = meas ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    end
    w4_meas = {3'b000, ((wc / 2) % 2) == 1};
    wc++;
  end

  int lg_ch[$]; longint lg_cnt[$]; bit lg_ovf[$];
  int w4_ch[$]; int w4_cnt[$]; bit w4_ovf[$];
  always @(negedge clk) begin
    if (valid && ready) begin lg_ch.push_back(rch); lg_cnt.push_back(rcnt); lg_ovf.push_back(rovf); end
    if (w4_valid && ready) begin w4_ch.push_back(w4_rch); w4_cnt.push_back(w4_rcnt); w4_ovf.push_back(w4_rovf); end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk(nm, ok, 1);
  endtask

  task automatic clear_log();
    lg_ch.delete(); lg_cnt.delete(); lg_ovf.delete();
  endtask

  task automatic run_gate(input string nm, input int g, input logic [1:0] md,
                          input longint e0, input longint e1, input longint e2, input longint e3);
    longint ex[4];
    int s;
    bit ok = 0;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    gate = g; edge_mode = md; ready = 1; cont = 0;
    clear_log();
    start = 1; step(); start = 0;
    s = cyc - 1;
    for (int i = 0; i < g + 20; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({nm, "_done_seen"}, ok, 1);
    chk({nm, "_gate_len"}, cyc - 1 - s, g);
    wait_idle({nm, "_idle"}, 50);
    chk({nm, "_beats"}, lg_ch.size(), 4);
    if (lg_ch.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk({nm, "_ch"}, lg_ch[i], i);
        chk({nm, "_cnt"}, lg_cnt[i], ex[i]);
        chk({nm, "_ovf"}, lg_ovf[i], 0);
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) step();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);  chk("rst_done", done, 0);  chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0); chk("rst_channel", rch, 0);
    chk("rst_count", rcnt, 0); chk("rst_ovf", rovf, 0);
    rst = 0; wave_en = 1;
    repeat (10) step();

    run_gate("rise", 1000, 2'b00, 20, 10, 0, 100);
    run_gate("both", 1000, 2'b10, 40, 20, 0, 200);
    run_gate("fall", 1000, 2'b01, 20, 10, 0, 100);

    // 4-bit counter saturation: 25 rising edges in 100 cycles
    gate = 100; edge_mode = 2'b00; ready = 1;
    w4_start = 1; step(); w4_start = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!w4_busy && w4_ch.size() == 4) begin ok = 1; break; end
    end
    chk("w4_complete", ok, 1);
    if (w4_ch.size() == 4) begin
      chk("w4_cnt0", w4_cnt[0], 15); chk("w4_ovf0", w4_ovf[0], 1);
      for (int i = 1; i < 4; i++) begin
        chk("w4_cnt", w4_cnt[i], 0); chk("w4_ovf", w4_ovf[i], 0);
      end
    end
    chk("w4_overrun", w4_overrun, 0);

    // backpressure
    gate = 20; ready = 0; clear_log();
    start = 1; step(); start = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("bp_done_seen", ok, 1);
    repeat (7) step();
    for (int i = 0; i < 60 && busy; i++) begin ready = ~ready; step(); end
    chk("bp_busy_low", busy, 0);
    chk("bp_beats", lg_ch.size(), 4);
    ready = 1;

    // continuous with stalled unload -> overrun
    gate = 8; cont = 1; ready = 0; clear_log();
    start = 1; step(); start = 0;
    repeat (20) step();
    @(negedge clk);
    chk("cont_overrun", overrun, 1);
    chk("cont_valid", valid, 1);
    ready = 1;
    repeat (6) step();
    stop = 1; step(); stop = 0; cont = 0;
    wait_idle("cont_stop_idle", 200);
    chk("cont_beats_min", lg_ch.size() >= 4, 1);
    if (lg_ch.size() >= 4) for (int i = 0; i < 4; i++) chk("cont_order", lg_ch[i], i);
    chk("cont_overrun_sticky", overrun, 1);

    // reset mid-gate
    gate = 100; step();
    start = 1; step(); start = 0;
    repeat (30) step();
    rst = 1; step();
    @(negedge clk);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_valid", valid, 0);
    chk("mid_rst_done", done, 0); chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_count", rcnt, 0); chk("mid_rst_channel", rch, 0);
    rst = 0; repeat (5) step();

    // G = 0 behaves as a one-cycle gate
    gate = 0; ready = 1;
    start = 1; step(); start = 0;
    @(negedge clk); chk("g0_not_yet", done, 0);
    step();
    @(negedge clk); chk("g0_done", done, 1);
    wait_idle("g0_idle", 20);

    // randomized traffic
    wave_en = 0; rand_en = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst   = ($urandom_range(0, 699) == 0);
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 14) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) begin
        gate = $urandom_range(0, 40);
        edge_mode = 2'($urandom_range(0, 3));
        cont = ($urandom_range(0, 1) == 1);
      end
    end
    step();
    rst = 0; start = 0; stop = 0; cont = 0; ready = 1;
    wait_idle("rand_final_idle", 400);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
